// File: rtl/sorted_merge_2x8.sv
// Two-bank stable merger: loads two key-sorted batches of eight words at once
// and streams all sixteen out in ascending key order, A winning key ties.
module sorted_merge_2x8 #(
  parameter int DSIZE  = 18,
  parameter int OFFSET = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] a0,
  input  logic [DSIZE-1:0] a1,
  input  logic [DSIZE-1:0] a2,
  input  logic [DSIZE-1:0] a3,
  input  logic [DSIZE-1:0] a4,
  input  logic [DSIZE-1:0] a5,
  input  logic [DSIZE-1:0] a6,
  input  logic [DSIZE-1:0] a7,
  input  logic [DSIZE-1:0] b0,
  input  logic [DSIZE-1:0] b1,
  input  logic [DSIZE-1:0] b2,
  input  logic [DSIZE-1:0] b3,
  input  logic [DSIZE-1:0] b4,
  input  logic [DSIZE-1:0] b5,
  input  logic [DSIZE-1:0] b6,
  input  logic [DSIZE-1:0] b7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_data,
  output logic             out_last
);

  typedef enum logic {IDLE, MERGE} state_t;

  state_t           state;
  logic [DSIZE-1:0] bank_a [8];
  logic [DSIZE-1:0] bank_b [8];
  logic [3:0]       pa;
  logic [3:0]       pb;
  logic [4:0]       cnt;

  logic             load;
  logic             beat;
  logic             take_a;
  logic             a_left;
  logic             b_left;
  logic [DSIZE-1:0] word_a;
  logic [DSIZE-1:0] word_b;

  assign load = in_valid && in_ready;
  assign beat = out_valid && out_ready;

  // Pointers run 0..8; bit 3 set means that bank is used up.
  assign a_left = !pa[3];
  assign b_left = !pb[3];
  assign word_a = bank_a[pa[2:0]];
  assign word_b = bank_b[pb[2:0]];

  assign take_a = !b_left ||
                  (a_left && (word_a[DSIZE-1:OFFSET] <= word_b[DSIZE-1:OFFSET]));

  assign out_data = out_valid ? (take_a ? word_a : word_b) : '0;
  assign out_last = out_valid && (cnt == 5'd15);

  // Banks are only written on a load, so stray in_valid during MERGE is harmless.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      bank_a[0] <= a0;
      bank_a[1] <= a1;
      bank_a[2] <= a2;
      bank_a[3] <= a3;
      bank_a[4] <= a4;
      bank_a[5] <= a5;
      bank_a[6] <= a6;
      bank_a[7] <= a7;
      bank_b[0] <= b0;
      bank_b[1] <= b1;
      bank_b[2] <= b2;
      bank_b[3] <= b3;
      bank_b[4] <= b4;
      bank_b[5] <= b5;
      bank_b[6] <= b6;
      bank_b[7] <= b7;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      pa        <= '0;
      pb        <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state     <= MERGE;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            pa        <= '0;
            pb        <= '0;
            cnt       <= '0;
          end
        end
        MERGE: begin
          if (beat) begin
            if (take_a) begin
              pa <= pa + 4'd1;
            end else begin
              pb <= pb + 4'd1;
            end
            cnt <= cnt + 5'd1;
            if (cnt == 5'd15) begin
              state     <= IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sorted_merge_2x8.sv
// Directed bench for sorted_merge_2x8: a stable-sort reference model is
// compared against the DUT every cycle, with literal sequences pinning it.
module tb_sorted_merge_2x8;

  localparam int DSIZE  = 18;
  localparam int OFFSET = 8;
  typedef logic [DSIZE-1:0] word_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b1;
  logic  in_valid = 1'b0;
  logic  out_ready = 1'b0;
  word_t cur_a [8];
  word_t cur_b [8];
  logic  in_ready;
  logic  out_valid;
  logic  out_last;
  word_t out_data;

  int    checks = 0;
  int    fails = 0;
  int    cycle = 0;
  int    load_count = 0;
  int    load_cycle [$];
  word_t exp_q [$];
  word_t out_log [$];
  word_t req_q [$];
  logic  prev_stall = 1'b0;
  word_t prev_data;
  logic  prev_last;

  always #5 clk = ~clk;

  sorted_merge_2x8 #(.DSIZE(DSIZE), .OFFSET(OFFSET)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a0(cur_a[0]), .a1(cur_a[1]), .a2(cur_a[2]), .a3(cur_a[3]),
    .a4(cur_a[4]), .a5(cur_a[5]), .a6(cur_a[6]), .a7(cur_a[7]),
    .b0(cur_b[0]), .b1(cur_b[1]), .b2(cur_b[2]), .b3(cur_b[3]),
    .b4(cur_b[4]), .b5(cur_b[5]), .b6(cur_b[6]), .b7(cur_b[7]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic word_t mk(input int key, input int sym);
    logic [DSIZE-OFFSET-1:0] k;
    logic [OFFSET-1:0]       s;
    k = key[DSIZE-OFFSET-1:0];
    s = sym[OFFSET-1:0];
    return {k, s};
  endfunction

  // Reference: A then B concatenated, then stable-sorted by key alone.
  task automatic build_expected();
    word_t m [16];
    word_t x;
    int    j;
    for (int i = 0; i < 8; i++) begin
      m[i]     = cur_a[i];
      m[i + 8] = cur_b[i];
    end
    for (int i = 1; i < 16; i++) begin
      x = m[i];
      j = i - 1;
      while (j >= 0 && m[j][DSIZE-1:OFFSET] > x[DSIZE-1:OFFSET]) begin
        m[j + 1] = m[j];
        j--;
      end
      m[j + 1] = x;
    end
    for (int i = 0; i < 16; i++) exp_q.push_back(m[i]);
  endtask

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    cycle++;
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
    end else begin
      check("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("out_data", 32'(out_data), 32'(exp_q[0]));
        check("out_last", 32'(out_last), 32'(exp_q.size() == 1));
        if (prev_stall) begin
          check("stall_data", 32'(out_data), 32'(prev_data));
          check("stall_last", 32'(out_last), 32'(prev_last));
        end
        prev_stall = !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        if (out_ready) begin
          out_log.push_back(out_data);
          void'(exp_q.pop_front());
        end
      end else begin
        check("idle_out_data", 32'(out_data), 32'd0);
        check("idle_out_last", 32'(out_last), 32'd0);
        prev_stall = 1'b0;
        if (in_valid) begin
          build_expected();
          load_count++;
          load_cycle.push_back(cycle);
        end
      end
    end
  end

  task automatic set_batch(input word_t a [8], input word_t b [8]);
    for (int i = 0; i < 8; i++) begin
      cur_a[i] = a[i];
      cur_b[i] = b[i];
    end
  endtask

  // Offer the current batch until one load is accepted.
  task automatic applyStimulus();
    int base;
    bit done;
    base = load_count;
    done = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk);
      #1;
      if (load_count != base) done = 1'b1;
    end
    in_valid = 1'b0;
    check("load_accepted", 32'(done), 32'd1);
  endtask

  task automatic wait_drain(input bit use_pattern);
    logic [31:0] pat;
    bit done;
    pat = 32'b1011_0010_1110_0101_0110_1001_1101_0011;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      out_ready = use_pattern ? pat[k % 32] : 1'b1;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) done = 1'b1;
    end
    out_ready = 1'b1;
    check("drain_in_time", 32'(done), 32'd1);
  endtask

  task automatic checkOutput(input string name);
    check({name, "_count"}, 32'(out_log.size()), 32'(req_q.size()));
    for (int i = 0; i < req_q.size() && i < out_log.size(); i++)
      check(name, 32'(out_log[i]), 32'(req_q[i]));
  endtask

  word_t ia [8], ib [8], ta [8], tb [8], xa [8], xb [8], ga [8], gb [8];

  initial begin
    for (int i = 0; i < 8; i++) begin
      ia[i] = mk(2 * i, i);
      ib[i] = mk(2 * i + 1, 8'h80 + i);
      ta[i] = mk(5, i);
      tb[i] = mk(5, 8'h10 + i);
      xa[i] = mk(i, 8'h40 + i);
      xb[i] = mk(100 + i, 8'h50 + i);
      ga[i] = mk(900 - i, 8'hEE);
      gb[i] = mk(3, 8'hDD);
    end
    set_batch(ia, ib);

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] basic interleave");
    out_ready = 1'b1;
    out_log.delete();
    applyStimulus();
    wait_drain(1'b0);
    req_q.delete();
    for (int i = 0; i < 16; i++) req_q.push_back(mk(i, (i % 2 == 0) ? i / 2 : 8'h80 + i / 2));
    checkOutput("interleave_seq");

    $display("[TB] ties");
    set_batch(ta, tb);
    out_log.delete();
    applyStimulus();
    wait_drain(1'b0);
    req_q.delete();
    for (int i = 0; i < 8; i++) req_q.push_back(mk(5, i));
    for (int i = 0; i < 8; i++) req_q.push_back(mk(5, 8'h10 + i));
    checkOutput("ties_seq");

    $display("[TB] bank exhaustion");
    set_batch(xa, xb);
    out_log.delete();
    applyStimulus();
    wait_drain(1'b0);
    req_q.delete();
    for (int i = 0; i < 8; i++) req_q.push_back(mk(i, 8'h40 + i));
    for (int i = 0; i < 8; i++) req_q.push_back(mk(100 + i, 8'h50 + i));
    checkOutput("exhaust_seq");

    $display("[TB] backpressure with ignored in_valid");
    set_batch(ia, ib);
    out_log.delete();
    out_ready = 1'b0;
    applyStimulus();
    set_batch(ga, gb);
    in_valid = 1'b1;
    repeat (6) begin
      out_ready = ~out_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_drain(1'b1);
    req_q.delete();
    for (int i = 0; i < 16; i++) req_q.push_back(mk(i, (i % 2 == 0) ? i / 2 : 8'h80 + i / 2));
    checkOutput("backpressure_seq");

    $display("[TB] reset mid-stream");
    set_batch(ia, ib);
    out_log.delete();
    out_ready = 1'b1;
    applyStimulus();
    for (int k = 0; k < 40 && out_log.size() < 5; k++) begin
      @(posedge clk);
      #1;
    end
    check("beats_before_reset", 32'(out_log.size()), 32'd5);
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_out_data", 32'(out_data), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    check("async_out_last", 32'(out_last), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    set_batch(xa, xb);
    out_log.delete();
    applyStimulus();
    wait_drain(1'b0);
    req_q.delete();
    for (int i = 0; i < 8; i++) req_q.push_back(mk(i, 8'h40 + i));
    for (int i = 0; i < 8; i++) req_q.push_back(mk(100 + i, 8'h50 + i));
    checkOutput("post_reset_seq");

    $display("[TB] back-to-back");
    set_batch(ta, tb);
    out_log.delete();
    load_cycle.delete();
    out_ready = 1'b1;
    begin
      int base;
      base = load_count;
      in_valid = 1'b1;
      for (int k = 0; k < 40 && load_count == base; k++) begin
        @(posedge clk);
        #1;
      end
      set_batch(xa, xb);
      for (int k = 0; k < 40 && load_count < base + 2; k++) begin
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      check("b2b_loads", 32'(load_count - base), 32'd2);
    end
    wait_drain(1'b0);
    if (load_cycle.size() >= 2)
      check("b2b_period", 32'(load_cycle[1] - load_cycle[0]), 32'd17);
    else
      check("b2b_period", 32'(load_cycle.size()), 32'd2);
    req_q.delete();
    for (int i = 0; i < 8; i++) req_q.push_back(mk(5, i));
    for (int i = 0; i < 8; i++) req_q.push_back(mk(5, 8'h10 + i));
    for (int i = 0; i < 8; i++) req_q.push_back(mk(i, 8'h40 + i));
    for (int i = 0; i < 8; i++) req_q.push_back(mk(100 + i, 8'h50 + i));
    checkOutput("b2b_seq");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sorted_merge_2x8.md
# sorted_merge_2x8

Sequential merger for the Huffman sort path. It accepts two independently sorted batches of eight `{frequency, symbol}` words, as produced by two 8-input bitonic sort networks, in a single load handshake. It then streams out the sixteen words in one ascending sequence, one word per accepted output beat. It sits between the sort networks and the Huffman tree-build stage, converting parallel sort results into a serial, fully ordered stream.

## Interface
- `DSIZE`, default 18: word width; packed as `{key[DSIZE-1:OFFSET], sym[OFFSET-1:0]}`.
- `OFFSET`, default 8: symbol field width; only `key` takes part in comparison.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `in_valid`, input, 1: batch offered on `a0..a7` / `b0..b7`.
- `in_ready`, output, 1: block can accept a batch.
- `a0..a7`, input, DSIZE each: batch A, ascending by key (`a0` smallest).
- `b0..b7`, input, DSIZE each: batch B, ascending by key (`b0` smallest).
- `out_valid`, output, 1: `out_data` holds a valid merged word.
- `out_ready`, input, 1: downstream accepts `out_data`.
- `out_data`, output, DSIZE: current merged word.
- `out_last`, output, 1: high with the 16th word of a batch.

## Operation
- FSM with two states.
  - IDLE: `in_ready`=1, `out_valid`=0.
  - MERGE: `in_ready`=0, `out_valid`=1.
- Load: `in_valid && in_ready` in IDLE.
  - Register all 16 inputs into banks A[0..7] and B[0..7].
  - Clear pointers `pa`, `pb` (4 bits each, range 0..8) and output count `cnt` (5 bits).
  - Go to MERGE.
- Selection is combinational from registered state.
  - `take_a` = (`pb`==8) or (`pa`<8 and `A[pa].key <= B[pb].key`).
  - Ties go to A.
  - Once one bank is exhausted, the other drains in order.
- `out_data` = `take_a ? A[pa] : B[pb]` in MERGE; 0 in IDLE.
- `out_last` = MERGE and (`cnt`==15).
- Output beat: `out_valid && out_ready`.
  - Increment `pa` if `take_a`, else increment `pb`.
  - Increment `cnt`.
  - On the beat where `cnt`==15, return to IDLE.
- Stall: `out_valid && !out_ready` holds all state; `out_data` and `out_last` stay stable.
- `in_valid` in MERGE is ignored; no bank corruption.
- Input batches are not checked for sortedness. With unsorted input the output order is unspecified, but exactly 16 words are still emitted.
- Symbols are carried untouched; equal keys keep A-before-B order, and order within a bank is preserved (stable merge).

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0, `pa`=`pb`=0, `cnt`=0.
- Load latency: first word is valid on the cycle after the load handshake.
- Throughput: one word per cycle with `out_ready` held high; a batch occupies 16 cycles in MERGE.
- Turnaround: `in_ready` rises the cycle after the last beat. Minimum batch period is 17 cycles (1 load + 16 out).
- Reset mid-MERGE aborts the batch immediately: outputs take their reset values, and no further words from the aborted batch are emitted after reset release.
- Bank registers need no reset.

## Test plan
Words below are written as `{key,sym}`.

- **Basic interleave.** A keys 0,2,4,..,14 (sym=idx), B keys 1,3,..,15 (sym=0x80+idx), `out_ready`=1.
  - Output keys 0..15 in consecutive cycles, first one cycle after load.
  - `out_last` high only with key 15.
  - `in_ready` returns high the next cycle.
- **Ties.** All A keys=5, syms 0..7; all B keys=5, syms 0x10..0x17.
  - Output syms 0..7, then 0x10..0x17.
- **Bank exhaustion.** A keys 0..7, B keys 100..107.
  - A drains fully first (`pa`=8), then B words 100..107 in order.
  - 16 beats, `out_last` on key 107.
- **Backpressure.** Scenario 1 with `out_ready` toggled in a pseudo-random pattern.
  - Same 16-word sequence.
  - `out_data` and `out_last` unchanged across every stalled cycle.
  - `in_valid` asserted during MERGE with a different batch has no effect.
- **Reset mid-stream.** Assert `rst_n`=0 after 5 beats.
  - `out_valid`=0, `out_data`=0, `in_ready`=1 asynchronously.
  - After release, a new load (scenario 3) produces a clean 16-word stream.
- **Back-to-back.** Two batches offered with `in_valid` held high.
  - Second load accepted exactly 17 cycles after the first.
  - No gap or duplicate words between batches.
